// File: rtl/hazard_ctrl_v2.sv
// hazard_ctrl_v2: stall/flush/forward control for the 5-stage RV32 pipeline
// Ports: D/E/M/W register addresses and write enables in; E result/PC source selects,
// MDU op/done and data-memory req/ready in; cnt_clr clears the perf counters.
// Out: E forward selects, F/D/E stalls, D/E/M/W bubbles, sticky mem_timeout,
// saturating stall_cycles and flush_count.
module hazard_ctrl_v2 #(
  parameter int         REG_AW      = 5,
  parameter bit         FORWARD_EN  = 1'b1,
  parameter logic [1:0] LOAD_SEL    = 2'b01,
  parameter int         MEM_TIMEOUT = 255,
  parameter int         CNT_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] D_rs1_addr,
  input  logic [REG_AW-1:0] D_rs2_addr,
  input  logic [REG_AW-1:0] E_rs1_addr,
  input  logic [REG_AW-1:0] E_rs2_addr,
  input  logic [REG_AW-1:0] E_rd_addr,
  input  logic [REG_AW-1:0] M_rd_addr,
  input  logic [REG_AW-1:0] W_rd_addr,
  input  logic              E_rd_wen,
  input  logic              M_rd_wen,
  input  logic              W_rd_wen,
  input  logic [1:0]        E_rd_src_sel,
  input  logic [1:0]        E_pc_src_sel,
  input  logic              E_mdu_op,
  input  logic              mdu_done,
  input  logic              M_mem_req,
  input  logic              mem_ready,
  input  logic              cnt_clr,
  output logic [1:0]        E_forward_src_a_sel,
  output logic [1:0]        E_forward_src_b_sel,
  output logic              F_stall_pc,
  output logic              F_stall_fetch_reg,
  output logic              stall_e,
  output logic              F_flush_fetch_reg,
  output logic              D_flush_decode_reg,
  output logic              flush_m,
  output logic              flush_w,
  output logic              mem_timeout,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count
);
  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(MEM_TIMEOUT);
  typedef enum logic {RUN, MEM_WAIT} state_t;
  state_t state, state_nx;
  logic [WC_W-1:0] wait_cnt, wait_nx;
  logic e1_m, e1_w, e2_m, e2_w, d_e, d_m;
  logic load_use, raw_stall, ld_stall, mem_stall, mdu_stall, redirect;
  // x0 is hard-wired zero, so a zero destination never creates a dependency
  assign e1_m = M_rd_wen && |M_rd_addr && M_rd_addr == E_rs1_addr;
  assign e1_w = W_rd_wen && |W_rd_addr && W_rd_addr == E_rs1_addr;
  assign e2_m = M_rd_wen && |M_rd_addr && M_rd_addr == E_rs2_addr;
  assign e2_w = W_rd_wen && |W_rd_addr && W_rd_addr == E_rs2_addr;
  assign d_e = E_rd_wen && |E_rd_addr && (E_rd_addr == D_rs1_addr || E_rd_addr == D_rs2_addr);
  assign d_m = M_rd_wen && |M_rd_addr && (M_rd_addr == D_rs1_addr || M_rd_addr == D_rs2_addr);
  assign load_use = E_rd_src_sel == LOAD_SEL && d_e;
  // write-first regfile: a W-stage producer is already visible in D
  assign raw_stall = !FORWARD_EN && (d_e || d_m);
  assign ld_stall = load_use || raw_stall;
  assign mem_stall = M_mem_req && !mem_ready;
  assign mdu_stall = E_mdu_op && !mdu_done;
  assign redirect = |E_pc_src_sel;
  always_comb begin
    E_forward_src_a_sel = 2'b00;
    E_forward_src_b_sel = 2'b00;
    F_stall_pc = 1'b0;
    F_stall_fetch_reg = 1'b0;
    stall_e = 1'b0;
    F_flush_fetch_reg = 1'b0;
    D_flush_decode_reg = 1'b0;
    flush_m = 1'b0;
    flush_w = 1'b0;
    if (reset) begin
      E_forward_src_a_sel = !FORWARD_EN ? 2'b00 : e1_m ? 2'b10 : e1_w ? 2'b01 : 2'b00;
      E_forward_src_b_sel = !FORWARD_EN ? 2'b00 : e2_m ? 2'b10 : e2_w ? 2'b01 : 2'b00;
      // a redirect squashes the wrong-path D instruction, so its hazard stall is moot
      F_stall_pc = mem_stall || mdu_stall || (!redirect && ld_stall);
      F_stall_fetch_reg = F_stall_pc;
      stall_e = mem_stall || mdu_stall;
      flush_w = mem_stall;
      flush_m = !mem_stall && mdu_stall;
      // redirect is held during E stalls and only acted on once E is free to advance
      F_flush_fetch_reg = !mem_stall && !mdu_stall && redirect;
      D_flush_decode_reg = !mem_stall && !mdu_stall && (redirect || ld_stall);
    end
  end
  always_comb begin
    state_nx = mem_stall ? MEM_WAIT : RUN;
    wait_nx = !mem_stall ? '0 : state == RUN ? WC_W'(1) : wait_cnt == WC_MAX ? wait_cnt : wait_cnt + 1'b1;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= RUN;
      wait_cnt <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state <= state_nx;
      wait_cnt <= wait_nx;
      mem_timeout <= mem_timeout || wait_nx == WC_MAX;
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      stall_cycles <= '0;
      flush_count <= '0;
    end else if (cnt_clr) begin
      stall_cycles <= '0;
      flush_count <= '0;
    end else begin
      if (F_stall_pc && ~&stall_cycles) stall_cycles <= stall_cycles + 1'b1;
      if (F_flush_fetch_reg && ~&flush_count) flush_count <= flush_count + 1'b1;
    end
endmodule

// File: tb/tb_hazard_ctrl_v2.sv
// tb_hazard_ctrl_v2: directed scoreboard bench for hazard_ctrl_v2 (forwarding and stalling builds)
module tb_hazard_ctrl_v2;
  logic clk = 1'b0;
  logic reset;
  logic [4:0] D_rs1_addr, D_rs2_addr, E_rs1_addr, E_rs2_addr, E_rd_addr, M_rd_addr, W_rd_addr;
  logic E_rd_wen, M_rd_wen, W_rd_wen, E_mdu_op, mdu_done, M_mem_req, mem_ready, cnt_clr;
  logic [1:0] E_rd_src_sel, E_pc_src_sel;
  logic [1:0] fa0, fb0, fa1, fb1;
  logic spc0, sfr0, se0, ff0, fd0, fm0, fw0, to0;
  logic spc1, sfr1, se1, ff1, fd1, fm1, fw1, to1;
  logic [3:0] st0, fl0;
  logic [31:0] st1, fl1;
  logic [11:0] o0, o1;
  typedef struct {string tag; logic [11:0] e0; logic [11:0] e1;} exp_t;
  exp_t sb[$];
  int n_chk = 0, n_fail = 0;
  logic [3:0] m_st0, m_fl0;
  logic [31:0] m_st1, m_fl1;
  localparam logic [11:0] LU = 12'h0C8, RD = 12'h018, MEM = 12'h0E2, MDU = 12'h0E4;
  always #5 clk = ~clk;
  hazard_ctrl_v2 #(.REG_AW(5), .FORWARD_EN(1'b1), .LOAD_SEL(2'b01), .MEM_TIMEOUT(4), .CNT_W(4)) u0 (
    .clk(clk), .reset(reset), .D_rs1_addr(D_rs1_addr), .D_rs2_addr(D_rs2_addr),
    .E_rs1_addr(E_rs1_addr), .E_rs2_addr(E_rs2_addr), .E_rd_addr(E_rd_addr), .M_rd_addr(M_rd_addr),
    .W_rd_addr(W_rd_addr), .E_rd_wen(E_rd_wen), .M_rd_wen(M_rd_wen), .W_rd_wen(W_rd_wen),
    .E_rd_src_sel(E_rd_src_sel), .E_pc_src_sel(E_pc_src_sel), .E_mdu_op(E_mdu_op), .mdu_done(mdu_done),
    .M_mem_req(M_mem_req), .mem_ready(mem_ready), .cnt_clr(cnt_clr),
    .E_forward_src_a_sel(fa0), .E_forward_src_b_sel(fb0), .F_stall_pc(spc0), .F_stall_fetch_reg(sfr0),
    .stall_e(se0), .F_flush_fetch_reg(ff0), .D_flush_decode_reg(fd0), .flush_m(fm0), .flush_w(fw0),
    .mem_timeout(to0), .stall_cycles(st0), .flush_count(fl0));
  hazard_ctrl_v2 #(.REG_AW(5), .FORWARD_EN(1'b0), .LOAD_SEL(2'b01), .MEM_TIMEOUT(255), .CNT_W(32)) u1 (
    .clk(clk), .reset(reset), .D_rs1_addr(D_rs1_addr), .D_rs2_addr(D_rs2_addr),
    .E_rs1_addr(E_rs1_addr), .E_rs2_addr(E_rs2_addr), .E_rd_addr(E_rd_addr), .M_rd_addr(M_rd_addr),
    .W_rd_addr(W_rd_addr), .E_rd_wen(E_rd_wen), .M_rd_wen(M_rd_wen), .W_rd_wen(W_rd_wen),
    .E_rd_src_sel(E_rd_src_sel), .E_pc_src_sel(E_pc_src_sel), .E_mdu_op(E_mdu_op), .mdu_done(mdu_done),
    .M_mem_req(M_mem_req), .mem_ready(mem_ready), .cnt_clr(cnt_clr),
    .E_forward_src_a_sel(fa1), .E_forward_src_b_sel(fb1), .F_stall_pc(spc1), .F_stall_fetch_reg(sfr1),
    .stall_e(se1), .F_flush_fetch_reg(ff1), .D_flush_decode_reg(fd1), .flush_m(fm1), .flush_w(fw1),
    .mem_timeout(to1), .stall_cycles(st1), .flush_count(fl1));
  assign o0 = {fa0, fb0, spc0, sfr0, se0, ff0, fd0, fm0, fw0, to0};
  assign o1 = {fa1, fb1, spc1, sfr1, se1, ff1, fd1, fm1, fw1, to1};
  task automatic idle();
    {D_rs1_addr, D_rs2_addr, E_rs1_addr, E_rs2_addr, E_rd_addr, M_rd_addr, W_rd_addr} = '0;
    {E_rd_wen, M_rd_wen, W_rd_wen, E_mdu_op, mdu_done, M_mem_req, mem_ready, cnt_clr} = '0;
    E_rd_src_sel = 2'b00;
    E_pc_src_sel = 2'b00;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s got %0d expected %0d", tag, got, want);
    end
  endtask
  task automatic cnt_chk(input string tag);
    chk({tag, "_st0"}, {28'd0, st0}, {28'd0, m_st0});
    chk({tag, "_fl0"}, {28'd0, fl0}, {28'd0, m_fl0});
    chk({tag, "_st1"}, st1, m_st1);
    chk({tag, "_fl1"}, fl1, m_fl1);
  endtask
  // one clock cycle: expectations queued with the stimulus, compared mid-cycle, counter model advanced
  task automatic step(input string tag, input logic [11:0] e0, input logic [11:0] e1);
    exp_t s;
    s.tag = tag;
    s.e0 = e0;
    s.e1 = e1;
    sb.push_back(s);
    @(negedge clk);
    s = sb.pop_front();
    n_chk++;
    assert (o0 === s.e0) else begin
      n_fail++;
      $error("FAIL %s u0 got %h expected %h", s.tag, o0, s.e0);
    end
    n_chk++;
    assert (o1 === s.e1) else begin
      n_fail++;
      $error("FAIL %s u1 got %h expected %h", s.tag, o1, s.e1);
    end
    if (!reset || cnt_clr) begin
      m_st0 = '0; m_fl0 = '0; m_st1 = '0; m_fl1 = '0;
    end else begin
      if (s.e0[7] && m_st0 != 4'hF) m_st0++;
      if (s.e0[4] && m_fl0 != 4'hF) m_fl0++;
      if (s.e1[7] && m_st1 != '1) m_st1++;
      if (s.e1[4] && m_fl1 != '1) m_fl1++;
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    m_st0 = '0; m_fl0 = '0; m_st1 = '0; m_fl1 = '0;
    idle();
    reset = 1'b0;
    M_mem_req = 1'b1; M_rd_addr = 5'd5; M_rd_wen = 1'b1; E_rs1_addr = 5'd5; D_rs1_addr = 5'd5; E_pc_src_sel = 2'b01;
    repeat (2) @(posedge clk);
    #1;
    step("reset", 12'h000, 12'h000);
    cnt_chk("reset_cnt");
    reset = 1'b1;
    idle();
    M_rd_addr = 5'd5; M_rd_wen = 1'b1; W_rd_addr = 5'd5; W_rd_wen = 1'b1; E_rs1_addr = 5'd5;
    step("fwd_m_over_w", 12'h800, 12'h000);
    M_rd_wen = 1'b0;
    step("fwd_w", 12'h400, 12'h000);
    M_rd_wen = 1'b1; M_rd_addr = 5'd0; W_rd_addr = 5'd0; E_rs1_addr = 5'd0;
    step("fwd_x0", 12'h000, 12'h000);
    M_rd_addr = 5'd6; W_rd_addr = 5'd9; E_rs1_addr = 5'd6; E_rs2_addr = 5'd9;
    step("fwd_a_m_b_w", 12'h900, 12'h000);
    idle();
    E_rd_src_sel = 2'b01; E_rd_addr = 5'd7; E_rd_wen = 1'b1; D_rs2_addr = 5'd7;
    step("load_use", LU, LU);
    E_pc_src_sel = 2'b01;
    step("lu_redirect", RD, RD);
    E_pc_src_sel = 2'b00; E_rd_src_sel = 2'b00; D_rs2_addr = 5'd0; D_rs1_addr = 5'd7;
    step("alu_dep", 12'h000, LU);
    E_rd_src_sel = 2'b01; E_rd_addr = 5'd0; D_rs1_addr = 5'd0;
    step("load_x0", 12'h000, 12'h000);
    idle();
    M_rd_addr = 5'd3; M_rd_wen = 1'b1; D_rs1_addr = 5'd3; E_rs1_addr = 5'd3;
    step("raw_m", 12'h800, LU);
    idle();
    W_rd_addr = 5'd4; W_rd_wen = 1'b1; D_rs2_addr = 5'd4; E_rs2_addr = 5'd4;
    step("raw_w", 12'h100, 12'h000);
    cnt_chk("pre_clr");
    idle();
    cnt_clr = 1'b1;
    step("clr", 12'h000, 12'h000);
    chk("clr_st0", {28'd0, st0}, 32'd0);
    idle();
    M_mem_req = 1'b1; E_pc_src_sel = 2'b01;
    repeat (3) step("mem_wait", MEM, MEM);
    mem_ready = 1'b1;
    step("mem_release", RD, RD);
    chk("mem_st0", {28'd0, st0}, 32'd3);
    chk("mem_fl0", {28'd0, fl0}, 32'd1);
    cnt_chk("mem_cnt");
    idle();
    step("idle", 12'h000, 12'h000);
    M_mem_req = 1'b1;
    repeat (4) step("to_wait", MEM, MEM);
    step("to_set", MEM | 12'h001, MEM);
    mem_ready = 1'b1;
    step("to_sticky", 12'h001, 12'h000);
    idle();
    step("to_hold", 12'h001, 12'h000);
    M_mem_req = 1'b1;
    repeat (2) step("rst_wait", MEM | 12'h001, MEM);
    reset = 1'b0;
    step("rst_mid", 12'h000, 12'h000);
    cnt_chk("rst_cnt");
    reset = 1'b1;
    idle();
    step("post_rst", 12'h000, 12'h000);
    E_mdu_op = 1'b1; M_mem_req = 1'b1; E_pc_src_sel = 2'b01;
    step("mdu_mem", MEM, MEM);
    M_mem_req = 1'b0;
    repeat (2) step("mdu_only", MDU, MDU);
    mdu_done = 1'b1;
    step("mdu_done", RD, RD);
    cnt_chk("mdu_cnt");
    idle();
    E_rd_src_sel = 2'b01; E_rd_addr = 5'd7; E_rd_wen = 1'b1; D_rs2_addr = 5'd7;
    repeat (20) step("lu_sat", LU, LU);
    chk("sat_st0", {28'd0, st0}, 32'd15);
    cnt_chk("sat_cnt");
    cnt_clr = 1'b1;
    step("clr_override", LU, LU);
    chk("clr_st0b", {28'd0, st0}, 32'd0);
    chk("clr_fl0b", {28'd0, fl0}, 32'd0);
    chk("clr_st1", st1, 32'd0);
    chk("clr_fl1", fl1, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
